mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (DM).
//  One transaction outstanding at a time. Data side has priority, with a starvation guard for fetch.
//  Sits between the pipeline's fetch/memory stages and the memory macro; the hazard unit stalls the pipeline on !gnt.
// PARAMETERS
//  ADDR_W      32  address width (byte address)
//  DATA_W      32  data width; byte enables are DATA_W/8 bits
//  STARVE_MAX  4   consecutive DM grants allowed while IF waits; range 1..15
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst_n       in   1         synchronous reset, active-low
//  if_req      in   1         fetch request; held high until if_gnt
//  if_addr     in   ADDR_W    fetch address
//  if_flush    in   1         discard response of the outstanding fetch
//  if_gnt      out  1         fetch request accepted this cycle
//  if_valid    out  1         1-cycle pulse: if_rdata valid
//  if_rdata    out  DATA_W    fetched instruction
//  dm_req      in   1         load/store request; held high until dm_gnt
//  dm_we       in   1         1 = store
//  dm_be       in   DATA_W/8  store byte enables
//  dm_addr     in   ADDR_W    data address
//  dm_wdata    in   DATA_W    store data
//  dm_gnt      out  1         data request accepted this cycle
//  dm_valid    out  1         1-cycle pulse: load data valid / store done
//  dm_rdata    out  DATA_W    load data
//  mem_req     out  1         1-cycle request strobe to memory
//  mem_we      out  1         memory write enable
//  mem_be      out  DATA_W/8  memory byte enables (all ones for fetch)
//  mem_addr    out  ADDR_W    memory address
//  mem_wdata   out  DATA_W    memory write data (0 for fetch)
//  mem_rvalid  in   1         memory completion (loads, fetches and stores)
//  mem_rdata   in   DATA_W    memory read data
//  busy        out  1         transaction outstanding (state != IDLE)
// BEHAVIOUR
//  Reset values: state=IDLE, starve_cnt=0, flush_pend=0; all gnt/valid/mem_req/mem_we low; busy=0.
//  FSM states: IDLE, BUSY_I, BUSY_D.
//  IDLE, grant selection (combinational, same cycle):
//   - dm_req && !(if_req && starve_cnt==STARVE_MAX) -> DM granted; next state BUSY_D.
//   - else if_req -> IF granted; next state BUSY_I.
//  Grant cycle: mem_req=1, mem_* driven from the winner, gnt=1. mem_req is never high outside IDLE.
//  BUSY_x, on mem_rvalid:
//   - *_valid=1 and *_rdata=mem_rdata in that same cycle (0 cycles added latency).
//   - Next state IDLE. The next grant comes at the earliest one cycle after completion.
//  starve_cnt:
//   - Incremented on a DM grant while if_req=1.
//   - Cleared on an IF grant, or on a DM grant while if_req=0.
//   - Saturates at STARVE_MAX.
//  if_flush:
//   - In BUSY_I it sets flush_pend; that fetch's if_valid is suppressed.
//   - flush and mem_rvalid in the same cycle -> suppressed too.
//   - Has no effect in IDLE or BUSY_D; flush_pend clears on return to IDLE.
//  mem_rvalid in IDLE is ignored; no valid is produced.
//  Reset mid-transaction: abort to IDLE; a late mem_rvalid is dropped by the IDLE rule.
//  Width rules:
//   - Fetch: mem_be='1, mem_we=0.
//   - DM: be/we/wdata pass through unmodified; stores also complete via mem_rvalid -> dm_valid.
//  if_rdata/dm_rdata are don't-care when their valid is low.
// TESTING
//  1) IF only, addr 0x100, mem_rvalid 2 cycles after req -> if_gnt cycle 0, if_valid cycle 2, if_rdata=mem_rdata; busy cycles 1-2.
//  2) if_req and dm_req both high in IDLE (starve_cnt=0) -> dm_gnt, mem_addr=dm_addr; if_gnt 1 cycle after DM completion.
//  3) dm_req held high 6 transactions, if_req held high, STARVE_MAX=4 -> 4 DM grants, then 1 IF grant, then DM resumes.
//  4) Store dm_we=1, be=4'b0011, wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; dm_valid on mem_rvalid.
//  5) if_flush in BUSY_I, then mem_rvalid 1 cycle later; also flush coinciding with rvalid -> no if_valid in either case; next grant proceeds.
//  6) rst_n low during BUSY_D, mem_rvalid arrives after release -> no dm_valid; state IDLE, outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and the data stage.
// One transaction in flight; data side wins unless fetch has been starved STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int         BE_W         = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_nxt_s;
    logic       flush_pend_r;
    logic       flush_pend_nxt_s;
    logic       grant_d_s;
    logic       grant_i_s;

    // Grant selection in IDLE; grants are held off while reset is asserted
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (dm_req && !(if_req && (starve_cnt_r == STARVE_MAX_C))) begin
                grant_d_s = 1'b1;
            end else if (if_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
        end
    end

    // Next-state, starvation counter and flush tracking
    always_comb begin
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = starve_cnt_r;
        flush_pend_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = ST_BUSY_D;
                end else if (grant_i_s) begin
                    state_nxt_s = ST_BUSY_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    flush_pend_nxt_s = flush_pend_r | if_flush;
                end
            end
            ST_BUSY_D: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY_D;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // A fetch only counts as starved while it is actually waiting
        if (grant_d_s && if_req) begin
            if (starve_cnt_r < STARVE_MAX_C) begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_nxt_s = STARVE_MAX_C;
            end
        end else if (grant_d_s || grant_i_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 4'd0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
        end
    end

    // Memory-side request mux and pipeline-side handshake/response
    always_comb begin
        if_gnt    = grant_i_s;
        dm_gnt    = grant_d_s;
        mem_req   = grant_i_s | grant_d_s;
        mem_we    = 1'b0;
        mem_be    = {BE_W{1'b0}};
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (grant_d_s) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_i_s) begin
            mem_be    = {BE_W{1'b1}};
            mem_addr  = if_addr;
        end else begin
            mem_we    = 1'b0;
        end
        // Flush arriving together with completion must also kill the response
        if_valid = rst_n && (state_r == ST_BUSY_I) && mem_rvalid && !flush_pend_r && !if_flush;
        dm_valid = rst_n && (state_r == ST_BUSY_D) && mem_rvalid;
        if_rdata = if_valid ? mem_rdata : {DATA_W{1'b0}};
        dm_rdata = dm_valid ? mem_rdata : {DATA_W{1'b0}};
        busy     = (state_r != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant priority, starvation guard, stores, flush, reset abort.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_valid;
    logic [3:0]  dm_be, mem_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // advance to just after the next rising edge, then inputs may change
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after an input change
    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; mem_rvalid = 1'b1;
        if_flush = 1'b0; dm_we = 1'b1; dm_be = 4'hF;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        tick(); tick(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({if_gnt, dm_gnt, mem_req, mem_we} !== 4'b0000) begin errors++;
            $display("FAIL reset_gnt got=%b exp=0000", {if_gnt, dm_gnt, mem_req, mem_we}); end
        checks++; if ({if_valid, dm_valid} !== 2'b00) begin errors++;
            $display("FAIL reset_valid got=%b exp=00", {if_valid, dm_valid}); end
        if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b0; dm_we = 1'b0;
        tick(); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_only();
        if_req = 1'b1; if_addr = 32'h100; settle();
        checks++; if ({if_gnt, dm_gnt, mem_req, busy} !== 4'b1010) begin errors++;
            $display("FAIL if_grant got=%b exp=1010", {if_gnt, dm_gnt, mem_req, busy}); end
        checks++; if ({mem_addr, mem_be, mem_we, mem_wdata} !== {32'h100, 4'hF, 1'b0, 32'h0}) begin errors++;
            $display("FAIL if_mem_fields addr=%h be=%h we=%b wd=%h exp 100/f/0/0", mem_addr, mem_be, mem_we, mem_wdata); end
        tick(); if_req = 1'b0; settle();
        checks++; if ({busy, mem_req, if_valid} !== 3'b100) begin errors++;
            $display("FAIL if_cycle1 got=%b exp=100", {busy, mem_req, if_valid}); end
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; settle();
        checks++; if ({if_valid, busy} !== 2'b11 || if_rdata !== 32'h13) begin errors++;
            $display("FAIL if_resp valid/busy=%b rdata=%h exp 11/00000013", {if_valid, busy}, if_rdata); end
        tick(); mem_rvalid = 1'b0; settle();
        checks++; if ({busy, if_valid} !== 2'b00) begin errors++;
            $display("FAIL if_done got=%b exp=00", {busy, if_valid}); end
    endtask

    task automatic test_dm_priority();
        if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_addr = 32'h200; settle();
        checks++; if ({dm_gnt, if_gnt} !== 2'b10 || mem_addr !== 32'h200) begin errors++;
            $display("FAIL prio_grant gnt=%b addr=%h exp 10/00000200", {dm_gnt, if_gnt}, mem_addr); end
        tick(); dm_req = 1'b0; settle();
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL prio_busy_ifgnt got=%b exp=0", if_gnt); end
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; settle();
        checks++; if ({dm_valid, if_gnt} !== 2'b10 || dm_rdata !== 32'hCAFE_0001) begin errors++;
            $display("FAIL prio_dm_resp v/g=%b rdata=%h exp 10/cafe0001", {dm_valid, if_gnt}, dm_rdata); end
        tick(); mem_rvalid = 1'b0; settle();
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h104) begin errors++;
            $display("FAIL prio_if_after gnt=%b addr=%h exp 1/00000104", if_gnt, mem_addr); end
        tick(); if_req = 1'b0;
        tick(); mem_rvalid = 1'b1;
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        logic [5:0] exp_d;
        exp_d = 6'b101111;
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h108; dm_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            settle();
            checks++; if ({dm_gnt, if_gnt} !== {exp_d[k], ~exp_d[k]}) begin errors++;
                $display("FAIL starve_grant_%0d got=%b exp=%b", k, {dm_gnt, if_gnt}, {exp_d[k], ~exp_d[k]}); end
            tick(); mem_rvalid = 1'b1;
            tick(); mem_rvalid = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h400; dm_wdata = 32'hDEAD_BEEF; settle();
        checks++; if ({dm_gnt, mem_req, mem_we, mem_be} !== 7'b111_0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h400) begin
            errors++; $display("FAIL store_fields g/r/we/be=%b wd=%h addr=%h exp 1110011/deadbeef/00000400",
                {dm_gnt, mem_req, mem_we, mem_be}, mem_wdata, mem_addr); end
        tick(); dm_req = 1'b0; dm_we = 1'b0; settle();
        checks++; if (dm_valid !== 1'b0 || mem_we !== 1'b0) begin errors++;
            $display("FAIL store_wait valid=%b we=%b exp 0/0", dm_valid, mem_we); end
        tick(); mem_rvalid = 1'b1; settle();
        checks++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", dm_valid); end
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h10C;
        tick(); if_req = 1'b0; if_flush = 1'b1; settle();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flush_set got=%b exp=0", if_valid); end
        tick(); if_flush = 1'b0; mem_rvalid = 1'b1; settle();
        checks++; if ({if_valid, busy} !== 2'b01) begin errors++;
            $display("FAIL flush_late_resp got=%b exp=01", {if_valid, busy}); end
        tick(); mem_rvalid = 1'b0; settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b exp=0", busy); end
        if_req = 1'b1;
        tick(); if_req = 1'b0; if_flush = 1'b1; mem_rvalid = 1'b1; settle();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flush_coincident got=%b exp=0", if_valid); end
        tick(); if_flush = 1'b0; mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h110; settle();
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h110) begin errors++;
            $display("FAIL flush_next_gnt gnt=%b addr=%h exp 1/00000110", if_gnt, mem_addr); end
        tick(); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093; settle();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h93) begin errors++;
            $display("FAIL flush_cleared valid=%b rdata=%h exp 1/00000093", if_valid, if_rdata); end
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_abort();
        dm_req = 1'b1; dm_addr = 32'h500;
        tick(); dm_req = 1'b0; rst_n = 1'b0;
        tick(); rst_n = 1'b1; settle();
        checks++; if ({busy, dm_gnt, if_gnt, mem_req, mem_we} !== 5'b00000) begin errors++;
            $display("FAIL abort_idle got=%b exp=00000", {busy, dm_gnt, if_gnt, mem_req, mem_we}); end
        mem_rvalid = 1'b1; settle();
        checks++; if ({dm_valid, if_valid, busy} !== 3'b000) begin errors++;
            $display("FAIL abort_late_rvalid got=%b exp=000", {dm_valid, if_valid, busy}); end
        tick(); mem_rvalid = 1'b0; settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_dm_priority();
        test_starvation();
        test_store();
        test_flush();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
